// File: rtl/dfr_run_sequencer_if.sv
// Signal bundle between the DFR run sequencer and its config, memory, reservoir and multiply
// neighbours. The master side is the sequencer.
interface dfr_run_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 32
);
    logic                  start;
    logic [CNT_WIDTH-1:0]  num_init_steps;
    logic [CNT_WIDTH-1:0]  num_train_steps;
    logic [CNT_WIDTH-1:0]  num_test_steps;
    logic [CNT_WIDTH-1:0]  num_steps_per_sample;
    logic                  busy;
    logic                  done;
    logic [1:0]            phase;
    logic                  in_mem_rd_en;
    logic [ADDR_WIDTH-1:0] in_mem_addr;
    logic [DATA_WIDTH-1:0] in_mem_rd_data;
    logic                  res_in_valid;
    logic [DATA_WIDTH-1:0] res_in_data;
    logic                  res_out_valid;
    logic [DATA_WIDTH-1:0] res_out_data;
    logic                  res_mem_wr_en;
    logic [ADDR_WIDTH-1:0] res_mem_addr;
    logic [DATA_WIDTH-1:0] res_mem_wr_data;
    logic                  mm_start;
    logic [ADDR_WIDTH-1:0] mm_base_addr;
    logic [CNT_WIDTH-1:0]  mm_sample_idx;
    logic                  mm_done;
    logic [CNT_WIDTH-1:0]  step_count;

    modport master (
        input  start, num_init_steps, num_train_steps, num_test_steps, num_steps_per_sample,
        input  in_mem_rd_data, res_out_valid, res_out_data, mm_done,
        output busy, done, phase, in_mem_rd_en, in_mem_addr, res_in_valid, res_in_data,
        output res_mem_wr_en, res_mem_addr, res_mem_wr_data, mm_start, mm_base_addr,
        output mm_sample_idx, step_count
    );

    modport slave (
        output start, num_init_steps, num_train_steps, num_test_steps, num_steps_per_sample,
        output in_mem_rd_data, res_out_valid, res_out_data, mm_done,
        input  busy, done, phase, in_mem_rd_en, in_mem_addr, res_in_valid, res_in_data,
        input  res_mem_wr_en, res_mem_addr, res_mem_wr_data, mm_start, mm_base_addr,
        input  mm_sample_idx, step_count
    );
endinterface

// File: rtl/dfr_run_sequencer.sv
// Runs one DFR pass through INIT, TRAIN and TEST: fetch a step, drive the reservoir, store the
// result, and kick the weight multiply after each complete TEST sample.
module dfr_run_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input logic                 clk,
    input logic                 rst,
    dfr_run_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        StIdle, StNextPhase, StRd, StRdWait, StDrive,
        StResWait, StStore, StMmStart, StMmWait, StFinish
    } state_e;

    localparam logic [1:0] PhInit  = 2'd0;
    localparam logic [1:0] PhTrain = 2'd1;
    localparam logic [1:0] PhTest  = 2'd2;
    localparam logic [1:0] PhIdle  = 2'd3;
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    state_e state_q, state_d;
    logic [1:0] phase_q, phase_d, next_phase;
    logic busy_q, busy_d, done_q, done_d;
    logic [CNT_WIDTH-1:0] init_q, init_d, train_q, train_d, test_q, test_d, sps_q, sps_d;
    logic [CNT_WIDTH-1:0] step_q, step_d, phase_cnt_q, phase_cnt_d;
    logic [CNT_WIDTH-1:0] sample_cnt_q, sample_cnt_d, store_cnt_q, store_cnt_d;
    logic [CNT_WIDTH-1:0] sample_idx_q, sample_idx_d;
    logic [DATA_WIDTH-1:0] res_in_data_q, res_in_data_d, res_data_q, res_data_d;
    logic [CNT_WIDTH-1:0] phase_target, mm_base;
    logic rd_en, in_valid, wr_en, mm_go;

    // First phase after the current one with a nonzero count; PhIdle also means "none left".
    always_comb begin
        next_phase = PhIdle;
        if (phase_q == PhIdle && init_q != '0) begin
            next_phase = PhInit;
        end else if ((phase_q == PhIdle || phase_q == PhInit) && train_q != '0) begin
            next_phase = PhTrain;
        end else if (phase_q != PhTest && test_q != '0) begin
            next_phase = PhTest;
        end
    end

    always_comb begin
        case (phase_q)
            PhInit:  phase_target = init_q;
            PhTrain: phase_target = train_q;
            PhTest:  phase_target = test_q;
            default: phase_target = '0;
        endcase
    end

    assign mm_base = store_cnt_q - sps_q;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        init_d        = init_q;
        train_d       = train_q;
        test_d        = test_q;
        sps_d         = sps_q;
        step_d        = step_q;
        phase_cnt_d   = phase_cnt_q;
        sample_cnt_d  = sample_cnt_q;
        store_cnt_d   = store_cnt_q;
        sample_idx_d  = sample_idx_q;
        res_in_data_d = res_in_data_q;
        res_data_d    = res_data_q;
        rd_en         = 1'b0;
        in_valid      = 1'b0;
        wr_en         = 1'b0;
        mm_go         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    init_d       = bus.num_init_steps;
                    train_d      = bus.num_train_steps;
                    test_d       = bus.num_test_steps;
                    sps_d        = bus.num_steps_per_sample;
                    step_d       = '0;
                    phase_cnt_d  = '0;
                    sample_cnt_d = '0;
                    store_cnt_d  = '0;
                    sample_idx_d = '0;
                    phase_d      = PhIdle;
                    busy_d       = 1'b1;
                    state_d      = StNextPhase;
                end
            end
            StNextPhase: begin
                phase_cnt_d = '0;
                phase_d     = next_phase;
                state_d     = (next_phase == PhIdle) ? StFinish : StRd;
            end
            StRd: begin
                rd_en   = 1'b1;
                state_d = StRdWait;
            end
            StRdWait: begin
                res_in_data_d = bus.in_mem_rd_data;
                state_d       = StDrive;
            end
            StDrive: begin
                in_valid = 1'b1;
                state_d  = StResWait;
            end
            StResWait: begin
                if (bus.res_out_valid) begin
                    res_data_d = bus.res_out_data;
                    state_d    = StStore;
                end
            end
            StStore: begin
                step_d      = step_q + CntOne;
                phase_cnt_d = phase_cnt_q + CntOne;
                if (phase_q != PhInit) begin
                    wr_en       = 1'b1;
                    store_cnt_d = store_cnt_q + CntOne;
                end
                if (phase_q == PhTest) begin
                    sample_cnt_d = sample_cnt_q + CntOne;
                end
                if (phase_q == PhTest && sps_q != '0 && sample_cnt_q + CntOne == sps_q) begin
                    state_d = StMmStart;
                end else if (phase_cnt_q + CntOne == phase_target) begin
                    state_d = StNextPhase;
                end else begin
                    state_d = StRd;
                end
            end
            StMmStart: begin
                mm_go   = 1'b1;
                state_d = StMmWait;
            end
            StMmWait: begin
                if (bus.mm_done) begin
                    sample_idx_d = sample_idx_q + CntOne;
                    sample_cnt_d = '0;
                    state_d      = (phase_cnt_q == phase_target) ? StNextPhase : StRd;
                end
            end
            StFinish: begin
                // done and the busy drop land together in the following (idle) cycle.
                busy_d  = 1'b0;
                done_d  = 1'b1;
                phase_d = PhIdle;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            phase_q       <= PhIdle;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            init_q        <= '0;
            train_q       <= '0;
            test_q        <= '0;
            sps_q         <= '0;
            step_q        <= '0;
            phase_cnt_q   <= '0;
            sample_cnt_q  <= '0;
            store_cnt_q   <= '0;
            sample_idx_q  <= '0;
            res_in_data_q <= '0;
            res_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            init_q        <= init_d;
            train_q       <= train_d;
            test_q        <= test_d;
            sps_q         <= sps_d;
            step_q        <= step_d;
            phase_cnt_q   <= phase_cnt_d;
            sample_cnt_q  <= sample_cnt_d;
            store_cnt_q   <= store_cnt_d;
            sample_idx_q  <= sample_idx_d;
            res_in_data_q <= res_in_data_d;
            res_data_q    <= res_data_d;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.phase           = phase_q;
    assign bus.in_mem_rd_en    = rd_en;
    assign bus.in_mem_addr     = step_q[ADDR_WIDTH-1:0];
    assign bus.res_in_valid    = in_valid;
    assign bus.res_in_data     = res_in_data_q;
    assign bus.res_mem_wr_en   = wr_en;
    assign bus.res_mem_addr    = store_cnt_q[ADDR_WIDTH-1:0];
    assign bus.res_mem_wr_data = res_data_q;
    assign bus.mm_start        = mm_go;
    assign bus.mm_base_addr    = mm_base[ADDR_WIDTH-1:0];
    assign bus.mm_sample_idx   = sample_idx_q;
    assign bus.step_count      = step_q;
endmodule

// File: tb/tb_dfr_run_sequencer.sv
// Bench for dfr_run_sequencer: table of run configurations with hand-computed totals, plus
// directed reset-in-multiply-wait and idle reset sequences.
module tb_dfr_run_sequencer;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dfr_run_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    dfr_run_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int unsigned init;
        int unsigned train;
        int unsigned test;
        int unsigned sps;
        int unsigned stall;
        bit          mid_start;
        int unsigned reads;
        int unsigned writes;
        int unsigned mms;
        int unsigned steps;
        int unsigned seq;
        int unsigned busy_cyc;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Environment models: input memory, echoing reservoir, weight-multiply unit.
    int unsigned stall = 0;
    int unsigned mm_lat = 3;
    bit mm_auto = 1'b1;
    logic mm_done_model = 1'b0;
    logic mm_done_force = 1'b0;
    assign bus.mm_done = mm_done_model | mm_done_force;

    initial begin
        int unsigned rcnt, mcnt;
        logic [DW-1:0] rval, drv_data;
        logic [AW-1:0] rd_addr;
        bit seen_rd, seen_drv, seen_mm;
        rcnt = 0;
        mcnt = 0;
        rval = '0;
        bus.in_mem_rd_data = '0;
        bus.res_out_valid  = 1'b0;
        bus.res_out_data   = '0;
        forever begin
            @(negedge clk);
            seen_rd  = bus.in_mem_rd_en;
            rd_addr  = bus.in_mem_addr;
            seen_drv = bus.res_in_valid;
            drv_data = bus.res_in_data;
            seen_mm  = bus.mm_start;
            @(posedge clk);
            #1;
            bus.res_out_valid = 1'b0;
            mm_done_model     = 1'b0;
            if (rst) begin
                rcnt = 0;
                mcnt = 0;
            end else begin
                if (seen_rd) bus.in_mem_rd_data = DW'(300 * rd_addr);
                if (seen_drv) begin
                    rcnt = stall + 1;
                    rval = drv_data + 1;
                end
                if (rcnt > 0) begin
                    rcnt--;
                    if (rcnt == 0) begin
                        bus.res_out_valid = 1'b1;
                        bus.res_out_data  = rval;
                    end
                end
                if (seen_mm && mm_auto) mcnt = mm_lat;
                if (mcnt > 0) begin
                    mcnt--;
                    if (mcnt == 0) mm_done_model = 1'b1;
                end
            end
        end
    end

    // Monitor: per-event address/data checks and per-run tallies.
    int rd_n, wr_n, mm_n, done_n, busy_n, seq;
    logic [1:0] last_ph = 2'd3;
    logic prev_drv = 1'b0;
    int unsigned cur_init = 0, cur_train = 0, cur_sps = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.in_mem_rd_en) begin
                    check("rd_addr", bus.in_mem_addr, rd_n % 65536);
                    rd_n++;
                end
                if (bus.res_mem_wr_en) begin
                    check("wr_addr", bus.res_mem_addr, wr_n % 65536);
                    check("wr_data", bus.res_mem_wr_data, 300 * (cur_init + wr_n) + 1);
                    wr_n++;
                end
                if (bus.mm_start) begin
                    check("mm_base", bus.mm_base_addr, cur_train + mm_n * cur_sps);
                    check("mm_idx", bus.mm_sample_idx, mm_n);
                    mm_n++;
                end
                if (bus.res_in_valid) check("drive_single", prev_drv, 0);
                if (bus.done) begin
                    done_n++;
                    check("done_busy", bus.busy, 0);
                    check("done_phase", bus.phase, 3);
                end
                if (bus.busy) busy_n++;
                if (bus.phase != 2'd3 && bus.phase != last_ph) begin
                    seq = seq * 4 + int'(bus.phase) + 1;
                    last_ph = bus.phase;
                end
            end
            prev_drv = bus.res_in_valid;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the start edge.
    task automatic start_run(input vec_t v);
        bus.num_init_steps       = v.init;
        bus.num_train_steps      = v.train;
        bus.num_test_steps       = v.test;
        bus.num_steps_per_sample = v.sps;
        cur_init  = v.init;
        cur_train = v.train;
        cur_sps   = v.sps;
        stall     = v.stall;
        rd_n = 0; wr_n = 0; mm_n = 0; done_n = 0; busy_n = 0; seq = 0;
        last_ph = 2'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        cyc = 0;
        start_run(v);
        while (done_n == 0 && cyc < 5000) begin
            bus.start = v.mid_start && (cyc == 30);
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check($sformatf("v%0d_done_pulses", idx), done_n, 1);
        check($sformatf("v%0d_reads", idx), rd_n, v.reads);
        check($sformatf("v%0d_writes", idx), wr_n, v.writes);
        check($sformatf("v%0d_mm_starts", idx), mm_n, v.mms);
        check($sformatf("v%0d_step_count", idx), bus.step_count, v.steps);
        check($sformatf("v%0d_phase_seq", idx), seq, v.seq);
        check($sformatf("v%0d_busy_cycles", idx), busy_n, v.busy_cyc);
        check($sformatf("v%0d_idle_busy", idx), bus.busy, 0);
    endtask

    vec_t vecs[6];
    vec_t rv;

    initial begin
        int cyc;
        // init, train, test, sps, stall, mid_start | reads, writes, mms, steps, seq, busy
        vecs[0] = '{100, 0, 100, 100, 0, 1'b0, 200, 100, 1, 200, 7, 1008};
        vecs[1] = '{2, 3, 4, 2, 0, 1'b0, 9, 7, 2, 9, 27, 58};
        vecs[2] = '{0, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0, 0, 2};
        vecs[3] = '{2, 2, 4, 2, 10, 1'b1, 8, 6, 2, 8, 27, 133};
        vecs[4] = '{0, 0, 5, 2, 0, 1'b0, 5, 5, 2, 5, 3, 36};
        vecs[5] = '{1, 1, 3, 0, 0, 1'b0, 5, 4, 0, 5, 27, 30};

        bus.start = 1'b0;
        bus.num_init_steps = '0;
        bus.num_train_steps = '0;
        bus.num_test_steps = '0;
        bus.num_steps_per_sample = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_phase", bus.phase, 3);
        check("rst_step_count", bus.step_count, 0);
        check("rst_rd_en", bus.in_mem_rd_en, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Reset while waiting on the multiply; a late mm_done must be ignored.
        mm_auto = 1'b0;
        rv = '{2, 0, 4, 2, 0, 1'b0, 0, 0, 0, 0, 0, 0};
        start_run(rv);
        cyc = 0;
        while (mm_n == 0 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("mmwait_reached", mm_n, 1);
        @(posedge clk);
        #1;
        check("mmwait_busy_before_rst", bus.busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mmrst_busy", bus.busy, 0);
        check("mmrst_phase", bus.phase, 3);
        check("mmrst_in_addr", bus.in_mem_addr, 0);
        check("mmrst_res_addr", bus.res_mem_addr, 0);
        check("mmrst_mm_base", bus.mm_base_addr, 0);
        check("mmrst_mm_idx", bus.mm_sample_idx, 0);
        check("mmrst_step_count", bus.step_count, 0);
        check("mmrst_res_in_data", bus.res_in_data, 0);
        busy_n = 0;
        rd_n   = 0;
        done_n = 0;
        @(posedge clk);
        #2;
        mm_done_force = 1'b1;
        @(posedge clk);
        #2;
        mm_done_force = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("late_mm_busy", busy_n, 0);
        check("late_mm_reads", rd_n, 0);
        check("late_mm_done", done_n, 0);
        mm_auto = 1'b1;
        run_vec(vecs[1], 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dfr_run_sequencer.md
Name: dfr_run_sequencer

Overview:
- Sequences one DFR run through three phases in order: INIT, TRAIN, TEST.
- Fetches each input step from input memory and hands it to the reservoir, then waits for the reservoir response.
- Stores reservoir outputs to reservoir memory during TRAIN and TEST only.
- In TEST, starts the weight-multiply unit once per completed sample. Sits between the AXI config registers (start, step counts, busy) and the reservoir/memory datapath inside dfr_core_top.

Parameters:
- DATA_WIDTH, 32, width of input samples and reservoir data
- ADDR_WIDTH, 16, width of input and reservoir memory word addresses
- CNT_WIDTH, 32, width of step-count config fields and counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that launches a run
- num_init_steps  in  CNT_WIDTH  INIT-phase step count
- num_train_steps  in  CNT_WIDTH  TRAIN-phase step count
- num_test_steps  in  CNT_WIDTH  TEST-phase step count
- num_steps_per_sample  in  CNT_WIDTH  steps per TEST sample
- busy  out  1  high while a run is active
- done  out  1  one-cycle pulse at end of run
- phase  out  2  0=INIT, 1=TRAIN, 2=TEST, 3=idle
- in_mem_rd_en  out  1  input memory read strobe
- in_mem_addr  out  ADDR_WIDTH  input memory address
- in_mem_rd_data  in  DATA_WIDTH  read data, valid 1 cycle after rd_en
- res_in_valid  out  1  one-cycle strobe carrying res_in_data
- res_in_data  out  DATA_WIDTH  sample sent to reservoir
- res_out_valid  in  1  reservoir result valid
- res_out_data  in  DATA_WIDTH  reservoir result
- res_mem_wr_en  out  1  reservoir memory write strobe
- res_mem_addr  out  ADDR_WIDTH  reservoir memory write address
- res_mem_wr_data  out  DATA_WIDTH  reservoir memory write data
- mm_start  out  1  one-cycle pulse to the weight-multiply unit
- mm_base_addr  out  ADDR_WIDTH  reservoir address of the first step of the sample
- mm_sample_idx  out  CNT_WIDTH  TEST sample index for the output memory
- mm_done  in  1  multiply complete
- step_count  out  CNT_WIDTH  total steps completed in this run (debug register)

Behaviour:
- Reset, whether applied idle or mid-run, forces state IDLE. All strobes go to 0, as do busy, step_count, all addresses, mm_sample_idx and res_in_data. phase=3. Any pending reservoir or multiply response is ignored.
- States: IDLE, NEXT_PHASE, RD, RD_WAIT, DRIVE, RES_WAIT, STORE, MM_START, MM_WAIT, FINISH.
- IDLE: on start, latch all four config inputs, clear counters, set busy=1 and go to NEXT_PHASE. start is ignored while busy.
- NEXT_PHASE: select the next phase after the current one that has a nonzero step count; zero-count phases are skipped. Clear the in-phase step counter. If no phase remains, go to FINISH.
- RD: in_mem_rd_en=1 and in_mem_addr=global step index, which runs 0..(init+train+test-1) continuously across phases.
- RD_WAIT: capture in_mem_rd_data into res_in_data.
- DRIVE: res_in_valid=1 for exactly one cycle.
- RES_WAIT: hold until res_out_valid=1, then capture res_out_data. A res_out_valid that arrives in any other state is dropped.
- STORE, in TRAIN or TEST: res_mem_wr_en=1, res_mem_addr=store counter, wr_data=captured result; then increment the store counter. The store counter starts at 0 and runs contiguously across TRAIN and TEST. In INIT there is no write.
- STORE, every phase: increment step_count, the global index and the in-phase counter.
- Exit from STORE, in priority order:
  - TEST and the sample-step counter reaches num_steps_per_sample: go to MM_START.
  - Phase count reached: go to NEXT_PHASE.
  - Otherwise: go to RD.
- MM_START: mm_start=1 for one cycle, with mm_base_addr = store counter − num_steps_per_sample and the current mm_sample_idx.
- MM_WAIT: wait for mm_done, then increment mm_sample_idx, clear the sample-step counter, and apply the phase-count check as above.
- If num_steps_per_sample=0, no multiply is ever started. A trailing partial TEST sample gets no multiply.
- Minimum step cost is 5 cycles when res_out_valid arrives the cycle after DRIVE.
- FINISH: done=1 for one cycle, busy=0 in the same cycle, phase=3, go to IDLE. step_count holds until the next start.
- All counters are CNT_WIDTH wide. Addresses are the low ADDR_WIDTH bits of their counters and wrap silently.
- busy is a registered output.
- With all counts 0, start causes busy for exactly 2 cycles (NEXT_PHASE, FINISH) and then the done pulse.

Test Plan:
- init=100, train=0, test=100, sps=100, reservoir echoes input+1 one cycle after DRIVE, in_mem[i]=300i -> 200 reads at addr 0..199; 100 writes at res addr 0..99 with data 30001..59701; one mm_start with base=0, idx=0; step_count=200; one done pulse.
- init=2, train=3, test=4, sps=2 -> phase sequence 0,1,2; 7 writes at addr 0..6; mm_start twice with base=3 then 5 and idx=0 then 1; step_count=9.
- All counts 0 -> busy high for 2 cycles, done pulse, no reads or writes.
- Reservoir stalls 10 cycles per step, and a start pulse arrives mid-run -> DRIVE pulses stay single-cycle; the second start is ignored; results are unchanged.
- rst asserted while in MM_WAIT -> next cycle busy=0, phase=3; a late mm_done is ignored; a new start runs cleanly from addr 0.
- test=5, sps=2 -> multiplies at bases 0 and 2 only; 5 writes; done pulse after the 5th STORE.
